pipelined_mac_pe: RTL

PIPELINED_MAC_PE -- requirements
Module: pipelined_mac_pe

---
 rtl/pipelined_mac_pe.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/pipelined_mac_pe.sv
// Two-stage multiply-accumulate processing element producing one result per tile.
// Stage 1 registers lane products, stage 2 reduces them into a wrap or saturating accumulator.
module pipelined_mac_pe #(
    parameter int InDataWidth  = 8,
    parameter int NumInputs    = 4,
    parameter int OutDataWidth = 32,
    parameter int CntWidth     = 16,
    parameter bit SaturateEn   = 1'b0
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic [NumInputs*InDataWidth-1:0]    a_i,
    input  logic [NumInputs*InDataWidth-1:0]    b_i,
    input  logic                                in_valid_i,
    output logic                                in_ready_o,
    input  logic                                signed_i,
    input  logic [CntWidth-1:0]                 num_beats_i,
    input  logic                                acc_clr_i,
    output logic signed [OutDataWidth-1:0]      c_o,
    output logic                                c_valid_o,
    input  logic                                c_ready_i,
    output logic                                ovf_o
);

    localparam int PW   = 2 * InDataWidth + 1;
    localparam int SumW = PW + $clog2(NumInputs) + 1;
    localparam int ExtW = ((OutDataWidth > SumW) ? OutDataWidth : SumW) + 1;
    localparam logic signed [ExtW-1:0] MaxV =
        {{(ExtW-OutDataWidth+1){1'b0}}, {(OutDataWidth-1){1'b1}}};
    localparam logic signed [ExtW-1:0] MinV = ~MaxV;

    typedef enum logic [1:0] {IDLE, ACC, DRAIN, OUT} state_t;

    state_t                         state_q;
    logic [CntWidth-1:0]            target_q;
    logic [CntWidth-1:0]            cnt_q;
    logic                           s1_valid_q;
    logic signed [PW-1:0]           prod_q [NumInputs];
    logic signed [OutDataWidth-1:0] acc_q;
    logic signed [OutDataWidth-1:0] c_q;
    logic                           c_valid_q;
    logic                           ovf_q;

    logic signed [PW-1:0]           a_ext  [NumInputs];
    logic signed [PW-1:0]           b_ext  [NumInputs];
    logic signed [PW-1:0]           prod_d [NumInputs];
    logic signed [ExtW-1:0]         psum;
    logic signed [ExtW-1:0]         total;
    logic signed [OutDataWidth-1:0] acc_next;
    logic                           ovf_add;
    logic                           accept;
    logic [CntWidth-1:0]            nb_eff;
    logic [CntWidth-1:0]            cnt_inc;

    assign in_ready_o = (state_q == IDLE) || (state_q == ACC);
    assign accept     = in_valid_i && in_ready_o;
    assign nb_eff     = (num_beats_i == '0) ? CntWidth'(1) : num_beats_i;
    assign cnt_inc    = cnt_q + CntWidth'(1);

    // Operands widened by one bit so unsigned mode fits a signed product.
    always_comb begin
        for (int j = 0; j < NumInputs; j++) begin
            a_ext[j] = {{(PW-InDataWidth){signed_i & a_i[j*InDataWidth+InDataWidth-1]}},
                        a_i[j*InDataWidth +: InDataWidth]};
            b_ext[j] = {{(PW-InDataWidth){signed_i & b_i[j*InDataWidth+InDataWidth-1]}},
                        b_i[j*InDataWidth +: InDataWidth]};
            prod_d[j] = a_ext[j] * b_ext[j];
        end
    end

    // Sum kept wide enough that overflow is judged on the true value.
    always_comb begin
        psum = '0;
        for (int j = 0; j < NumInputs; j++) begin
            psum = psum + {{(ExtW-PW){prod_q[j][PW-1]}}, prod_q[j]};
        end
        total   = {{(ExtW-OutDataWidth){acc_q[OutDataWidth-1]}}, acc_q} + psum;
        ovf_add = (total > MaxV) || (total < MinV);
        if (SaturateEn && ovf_add) begin
            acc_next = total[ExtW-1] ? MinV[OutDataWidth-1:0] : MaxV[OutDataWidth-1:0];
        end else begin
            acc_next = total[OutDataWidth-1:0];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            target_q   <= '0;
            cnt_q      <= '0;
            s1_valid_q <= 1'b0;
            acc_q      <= '0;
            c_q        <= '0;
            c_valid_q  <= 1'b0;
            ovf_q      <= 1'b0;
            for (int j = 0; j < NumInputs; j++) prod_q[j] <= '0;
        end else if (acc_clr_i) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            s1_valid_q <= 1'b0;
            acc_q      <= '0;
            c_q        <= '0;
            c_valid_q  <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            s1_valid_q <= accept;
            if (accept) begin
                for (int j = 0; j < NumInputs; j++) prod_q[j] <= prod_d[j];
            end
            if (s1_valid_q) begin
                acc_q <= acc_next;
                if (ovf_add) ovf_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        target_q <= nb_eff;
                        cnt_q    <= CntWidth'(1);
                        acc_q    <= '0;
                        ovf_q    <= 1'b0;
                        state_q  <= (nb_eff == CntWidth'(1)) ? DRAIN : ACC;
                    end
                end
                ACC: begin
                    if (accept) begin
                        cnt_q <= cnt_inc;
                        if (cnt_inc == target_q) state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (s1_valid_q) begin
                        c_q       <= acc_next;
                        c_valid_q <= 1'b1;
                        state_q   <= OUT;
                    end
                end
                OUT: begin
                    if (c_ready_i) begin
                        c_valid_q <= 1'b0;
                        state_q   <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign c_o       = c_q;
    assign c_valid_o = c_valid_q;
    assign ovf_o     = ovf_q;

endmodule
